// File: rtl/exception_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// exception_sequencer_pkg
// Shared types and constants for the exception sequencer of the 16-bit core:
// FSM state encoding, exception cause codes, HDU flush-request encodings,
// default handler vectors and a saturating counter helper.
// -----------------------------------------------------------------------------
package exception_sequencer_pkg;

  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;

  localparam logic [15:0] DEF_VEC_OVF = 16'h0060;
  localparam logic [15:0] DEF_VEC_OPC = 16'h0080;

  // Exception cause as delivered by the HDU on exc_cause.
  localparam logic CAUSE_OVF = 1'b0;
  localparam logic CAUSE_OPC = 1'b1;

  // hdu_which_flush request encodings.
  localparam logic [1:0] WF_NONE  = 2'b00;
  localparam logic [1:0] WF_IF_ID = 2'b01;
  localparam logic [1:0] WF_ID_EX = 2'b10;
  localparam logic [1:0] WF_BOTH  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RESTORE,
    ST_HALT
  } state_e;

  // 8-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/exception_sequencer_flush_counter.sv
// -----------------------------------------------------------------------------
// flush_counter
// Loadable 4-bit down-counter that times the full-pipeline flush window.
//   clk, rst_n   : clock, asynchronous active-low reset (count clears to 0)
//   i_load       : load i_load_val (has priority over i_dec)
//   i_load_val   : value to load
//   i_dec        : decrement by one; holds at zero
//   o_zero       : count is zero
// -----------------------------------------------------------------------------
module flush_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/exception_sequencer.sv
// -----------------------------------------------------------------------------
// exception_sequencer
// Pipeline control sequencer between the hazard detection unit and the
// PC/pipeline registers. Passes HDU stall/flush requests through while idle;
// on an exception latches EPC/cause, flushes the whole pipe for FLUSH_CYCLES
// cycles, redirects the PC to the cause's handler vector, and on eret
// restores the PC from EPC. An exception inside a handler halts the core.
//   Inputs : clk, rst_n, exc_req, exc_cause, fault_pc, eret, hdu_stall,
//            hdu_which_flush
//   Outputs: pc_enable, if_id_write, flush_if_id/id_ex/ex_mem, pc_load,
//            pc_target, epc, cause {double_fault, cause}, busy, halted,
//            exc_count (saturating)
// -----------------------------------------------------------------------------
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int unsigned        DATA_W       = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  VEC_OVF      = DEF_VEC_OVF,
  parameter logic [DATA_W-1:0]  VEC_OPC      = DEF_VEC_OPC,
  parameter int unsigned        FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exc_req,
  input  logic              exc_cause,
  input  logic [DATA_W-1:0] fault_pc,
  input  logic              eret,
  input  logic              hdu_stall,
  input  logic [1:0]        hdu_which_flush,
  output logic              pc_enable,
  output logic              if_id_write,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic [DATA_W-1:0] epc,
  output logic [1:0]        cause,
  output logic              busy,
  output logic              halted,
  output logic [7:0]        exc_count
);

  // Counter is loaded with FLUSH_CYCLES-1 so that FLUSH lasts FLUSH_CYCLES.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e            r_state;
  logic [DATA_W-1:0] r_epc;
  logic [1:0]        r_cause;
  logic [7:0]        r_exc_count;

  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;

  assign w_cnt_load = (r_state == ST_IDLE) && exc_req;
  assign w_cnt_dec  = (r_state == ST_FLUSH);

  flush_counter u_flush_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (FLUSH_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_epc       <= '0;
      r_cause     <= 2'b00;
      r_exc_count <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (exc_req) begin
            r_epc       <= fault_pc;
            r_cause     <= {1'b0, exc_cause};
            r_exc_count <= sat_inc8(r_exc_count);
            r_state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_cnt_zero) r_state <= ST_REDIRECT;
        end
        ST_REDIRECT: r_state <= ST_HANDLER;
        ST_HANDLER: begin
          // A new exception beats a simultaneous eret: double fault.
          if (exc_req) begin
            r_cause[1] <= 1'b1;
            r_state    <= ST_HALT;
          end else if (eret) begin
            r_state <= ST_RESTORE;
          end
        end
        ST_RESTORE: r_state <= ST_IDLE;
        ST_HALT:    r_state <= ST_HALT;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Shared "freeze and flush everything" output pattern.
  task automatic drive_full_flush();
    pc_enable    = 1'b0;
    if_id_write  = 1'b0;
    flush_if_id  = 1'b1;
    flush_id_ex  = 1'b1;
    flush_ex_mem = 1'b1;
  endtask

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    pc_enable    = ~hdu_stall;
    if_id_write  = ~hdu_stall;
    flush_if_id  = hdu_which_flush[0];
    flush_id_ex  = hdu_which_flush[1];
    flush_ex_mem = 1'b0;
    pc_load      = 1'b0;
    pc_target    = '0;
    halted       = 1'b0;

    case (r_state)
      ST_IDLE, ST_HANDLER: begin
        if (exc_req) drive_full_flush();
      end
      ST_FLUSH: drive_full_flush();
      ST_REDIRECT, ST_RESTORE: begin
        pc_enable    = 1'b1;
        if_id_write  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        pc_load      = 1'b1;
        if (r_state == ST_RESTORE) pc_target = r_epc;
        else                       pc_target = r_cause[0] ? VEC_OPC : VEC_OVF;
      end
      ST_HALT: begin
        drive_full_flush();
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign epc       = r_epc;
  assign cause     = r_cause;
  assign exc_count = r_exc_count;

endmodule

// File: tb/tb_exception_sequencer.sv
module tb_exception_sequencer;
  import exception_sequencer_pkg::*;

  localparam int FC = 2;

  logic        clk;
  logic        rst_n;
  logic        exc_req;
  logic        exc_cause;
  logic [15:0] fault_pc;
  logic        eret;
  logic        hdu_stall;
  logic [1:0]  hdu_which_flush;
  logic        pc_enable;
  logic        if_id_write;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [15:0] epc;
  logic [1:0]  cause;
  logic        busy;
  logic        halted;
  logic [7:0]  exc_count;

  exception_sequencer #(
    .DATA_W       (16),
    .VEC_OVF      (16'h0060),
    .VEC_OPC      (16'h0080),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .exc_req         (exc_req),
    .exc_cause       (exc_cause),
    .fault_pc        (fault_pc),
    .eret            (eret),
    .hdu_stall       (hdu_stall),
    .hdu_which_flush (hdu_which_flush),
    .pc_enable       (pc_enable),
    .if_id_write     (if_id_write),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .flush_ex_mem    (flush_ex_mem),
    .pc_load         (pc_load),
    .pc_target       (pc_target),
    .epc             (epc),
    .cause           (cause),
    .busy            (busy),
    .halted          (halted),
    .exc_count       (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {pc_enable, if_id_write, flush_if_id, flush_id_ex, flush_ex_mem, pc_load}
  function automatic logic [5:0] ctl();
    return {pc_enable, if_id_write, flush_if_id, flush_id_ex, flush_ex_mem, pc_load};
  endfunction

  localparam logic [5:0] CTL_FULL  = 6'b001110;
  localparam logic [5:0] CTL_LOAD  = 6'b111001;
  localparam logic [5:0] CTL_CLEAR = 6'b110000;

  // Advance to just after the next rising edge (the input drive point).
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_req         = 1'b0;
    exc_cause       = 1'b0;
    fault_pc        = 16'h0000;
    eret            = 1'b0;
    hdu_stall       = 1'b0;
    hdu_which_flush = WF_NONE;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks how many flush cycles remain and which one-shot
  // phase (redirect / handler / restore / halt) the sequence is in.
  // ---------------------------------------------------------------------------
  int          m_flush_left;
  bit          m_redir, m_handler, m_restore, m_halt;
  logic [15:0] m_epc;
  logic [1:0]  m_cause;
  int          m_cnt;

  task automatic model_reset();
    m_flush_left = 0;
    m_redir      = 0;
    m_handler    = 0;
    m_restore    = 0;
    m_halt       = 0;
    m_epc        = 16'h0000;
    m_cause      = 2'b00;
    m_cnt        = 0;
  endtask

  function automatic logic [49:0] model_out();
    logic        pe, iw, pl;
    logic [2:0]  f;
    logic [15:0] tgt;
    bit          idle;
    idle = (m_flush_left == 0) && !m_redir && !m_handler && !m_restore && !m_halt;
    pl  = 1'b0;
    tgt = 16'h0000;
    if (m_halt || m_flush_left > 0) begin
      pe = 0; iw = 0; f = 3'b111;
    end else if (m_redir || m_restore) begin
      pe = 1; iw = 1; f = 3'b100; pl = 1;
      tgt = m_restore ? m_epc : (m_cause[0] ? 16'h0080 : 16'h0060);
    end else if (exc_req) begin
      pe = 0; iw = 0; f = 3'b111;
    end else begin
      pe = !hdu_stall; iw = !hdu_stall;
      f = {hdu_which_flush[0], hdu_which_flush[1], 1'b0};
    end
    return {pe, iw, f, pl, tgt, !idle, m_halt, m_epc, m_cause, 8'(m_cnt)};
  endfunction

  function automatic logic [49:0] dut_out();
    return {pc_enable, if_id_write, flush_if_id, flush_id_ex, flush_ex_mem, pc_load,
            pc_target, busy, halted, epc, cause, exc_count};
  endfunction

  task automatic model_step();
    if (m_halt) begin
      // stays halted
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_redir = 1;
    end else if (m_redir) begin
      m_redir   = 0;
      m_handler = 1;
    end else if (m_restore) begin
      m_restore = 0;
    end else if (m_handler) begin
      if (exc_req) begin
        m_halt     = 1;
        m_handler  = 0;
        m_cause[1] = 1'b1;
      end else if (eret) begin
        m_restore = 1;
        m_handler = 0;
      end
    end else if (exc_req) begin
      m_epc        = fault_pc;
      m_cause      = {1'b0, exc_cause};
      m_cnt        = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_flush_left = FC;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Hand-written sequences. Each starts and ends at the drive point.
  // ---------------------------------------------------------------------------
  task automatic run_exc(input logic c, input logic [15:0] pc, input bit noise,
                         input logic [7:0] exp_cnt);
    logic [15:0] vec;
    vec = c ? 16'h0080 : 16'h0060;
    exc_req   = 1'b1;
    exc_cause = c;
    fault_pc  = pc;
    @(negedge clk);
    check("exc_accept_ctl", 64'(ctl()), 64'(CTL_FULL));
    adv();
    exc_req  = 1'b0;
    fault_pc = 16'hDEAD;
    for (int k = 0; k < FC; k++) begin
      if (noise) begin
        exc_req         = 1'b1;
        exc_cause       = ~c;
        eret            = 1'b1;
        hdu_stall       = 1'b1;
        hdu_which_flush = WF_BOTH;
        fault_pc        = 16'(($urandom & 32'hFFFF));
      end
      @(negedge clk);
      check("flush_ctl", 64'(ctl()), 64'(CTL_FULL));
      check("flush_busy", 64'(busy), 64'd1);
      adv();
    end
    if (noise) begin
      exc_req = 1'b1;
      eret    = 1'b1;
    end
    @(negedge clk);
    check("redirect_ctl", 64'(ctl()), 64'(CTL_LOAD));
    check("redirect_target", 64'(pc_target), 64'(vec));
    check("redirect_epc", 64'(epc), 64'(pc));
    check("redirect_cause", 64'(cause), 64'({1'b0, c}));
    check("redirect_count", 64'(exc_count), 64'(exp_cnt));
    adv();
    clear_inputs();
  endtask

  // From HANDLER: issue eret, expect restore from exp_epc, then IDLE.
  task automatic do_eret(input logic [15:0] exp_epc);
    eret = 1'b1;
    @(negedge clk);
    check("handler_ctl", 64'(ctl()), 64'(CTL_CLEAR));
    check("handler_busy", 64'(busy), 64'd1);
    adv();
    eret = 1'b0;
    @(negedge clk);
    check("restore_ctl", 64'(ctl()), 64'(CTL_LOAD));
    check("restore_target", 64'(pc_target), 64'(exp_epc));
    adv();
    @(negedge clk);
    check("after_restore_busy", 64'(busy), 64'd0);
    check("after_restore_ctl", 64'(ctl()), 64'(CTL_CLEAR));
    adv();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, 64'(ctl()), 64'(CTL_CLEAR));
    check({tag, "_regs"}, 64'({epc, cause, exc_count, busy, halted, pc_target}),
          64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    check_reset_state("reset_pulse");
    rst_n = 1'b1;
    adv();
  endtask

  typedef struct {
    logic       stall;
    logic [1:0] wf;
    logic [5:0] exp_ctl;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, WF_NONE,  6'b110000};
    tbl[1] = '{1'b0, WF_IF_ID, 6'b111000};
    tbl[2] = '{1'b0, WF_ID_EX, 6'b110100};
    tbl[3] = '{1'b0, WF_BOTH,  6'b111100};
    tbl[4] = '{1'b1, WF_NONE,  6'b000000};
    tbl[5] = '{1'b1, WF_IF_ID, 6'b001000};
    tbl[6] = '{1'b1, WF_ID_EX, 6'b000100};
    tbl[7] = '{1'b1, WF_BOTH,  6'b001100};

    clear_inputs();
    rst_n = 1'b0;
    #2;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // IDLE pass-through table.
    foreach (tbl[i]) begin
      hdu_stall       = tbl[i].stall;
      hdu_which_flush = tbl[i].wf;
      @(negedge clk);
      check($sformatf("passthru_%0d", i), 64'(ctl()), 64'(tbl[i].exp_ctl));
      check($sformatf("passthru_busy_%0d", i), 64'(busy), 64'd0);
      adv();
    end
    clear_inputs();

    // Overflow exception, then return.
    run_exc(CAUSE_OVF, 16'h0010, 1'b0, 8'd1);
    do_eret(16'h0010);

    // Illegal opcode exception, then return.
    run_exc(CAUSE_OPC, 16'h8010, 1'b0, 8'd2);
    do_eret(16'h8010);

    // Noise during FLUSH/REDIRECT must be ignored; timing unchanged.
    run_exc(CAUSE_OVF, 16'h1234, 1'b1, 8'd3);
    do_eret(16'h1234);

    // Double fault with simultaneous eret.
    run_exc(CAUSE_OPC, 16'h4242, 1'b0, 8'd4);
    exc_req = 1'b1;
    eret    = 1'b1;
    @(negedge clk);
    check("double_fault_ctl", 64'(ctl()), 64'(CTL_FULL));
    adv();
    clear_inputs();
    for (int k = 0; k < 12; k++) begin
      if (k == 5) begin
        eret    = 1'b1;
        exc_req = 1'b1;
      end
      @(negedge clk);
      check("halt_ctl", 64'(ctl()), 64'(CTL_FULL));
      check("halt_flags", 64'({halted, busy, cause, epc}), 64'({1'b1, 1'b1, 2'b11, 16'h4242}));
      adv();
      clear_inputs();
    end
    pulse_reset();

    // Asynchronous reset mid-FLUSH.
    exc_req  = 1'b1;
    fault_pc = 16'h0BAD;
    adv();
    exc_req = 1'b0;
    #2;
    check("mid_flush_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_reset_idle", 64'({pc_load, busy}), 64'd0);
    end
    adv();

    // Saturation of exc_count.
    for (int i = 0; i < 256; i++) begin
      logic c;
      logic [15:0] pc;
      c  = 1'($urandom_range(0, 1));
      pc = 16'($urandom_range(0, 16'hFFFF));
      run_exc(c, pc, 1'b0, (i < 255) ? 8'(i + 1) : 8'hFF);
      do_eret(pc);
    end
    @(negedge clk);
    check("count_saturated", 64'(exc_count), 64'hFF);
    adv();

    // Randomized run against the reference model.
    pulse_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
      end
      exc_req         = ($urandom_range(0, 9) == 0);
      exc_cause       = 1'($urandom_range(0, 1));
      fault_pc        = 16'($urandom_range(0, 16'hFFFF));
      eret            = ($urandom_range(0, 3) == 0);
      hdu_stall       = 1'($urandom_range(0, 1));
      hdu_which_flush = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("random", 64'(dut_out()), 64'(model_out()));
      model_step();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Multi-cycle pipeline control sequencer between the hazard detection unit and the PC/pipeline registers of the 16-bit datapath.
- In normal operation it passes HDU stall and flush requests through.
- On a caught exception it latches EPC and cause, flushes the pipeline for a fixed number of cycles, then redirects the PC to a per-cause handler vector.
- On return-from-exception it restores the PC from EPC. A nested exception inside a handler is a double fault and halts the core.

Parameters:
- DATA_W, 16, datapath/PC width.
- VEC_OVF, 16'h0060, handler address for arithmetic overflow (cause 0).
- VEC_OPC, 16'h0080, handler address for illegal opcode (cause 1).
- FLUSH_CYCLES, 2, number of full-flush cycles after the exception cycle (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- exc_req  in  1  exception caught (from HDU)
- exc_cause  in  1  0 = overflow, 1 = illegal opcode
- fault_pc  in  DATA_W  PC of faulting instruction
- eret  in  1  handler-complete / return request
- hdu_stall  in  1  load-use stall request
- hdu_which_flush  in  2  00 none, 01 IF/ID, 10 ID/EX, 11 IF/ID+ID/EX
- pc_enable  out  1  PC register write enable
- if_id_write  out  1  IF/ID register write enable
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  stage flush (bubble insert)
- pc_load  out  1  force PC to pc_target this cycle
- pc_target  out  DATA_W  forced PC value
- epc  out  DATA_W  latched fault PC
- cause  out  2  bit0 = latched exc_cause, bit1 = double fault
- busy  out  1  high in any state other than IDLE
- halted  out  1  high in HALT
- exc_count  out  8  saturating count of accepted exceptions

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; epc = 0, cause = 0, exc_count = 0, flush counter = 0.
  - All outputs take their IDLE values with exc_req = 0, so pc_enable = 1 and if_id_write = 1.
- FSM states: IDLE, FLUSH, REDIRECT, HANDLER, RESTORE, HALT. State, counter, epc, cause and exc_count are registers. Outputs are decoded combinationally from state and inputs.
- IDLE, no exc_req (pass-through):
  - pc_enable = if_id_write = ~hdu_stall.
  - flush_if_id = hdu_which_flush[0]; flush_id_ex = hdu_which_flush[1]; flush_ex_mem = 0; pc_load = 0.
- IDLE, exc_req = 1 (overrides stall and flush inputs):
  - Same cycle: pc_enable = 0, if_id_write = 0, all three flushes = 1.
  - At the clock edge: epc <= fault_pc; cause <= {1'b0, exc_cause}; exc_count += 1, saturating at 255; counter <= FLUSH_CYCLES-1; state -> FLUSH.
- FLUSH:
  - All flushes = 1; pc_enable = 0; if_id_write = 0.
  - Counter decrements each cycle; at 0 -> REDIRECT.
  - Total FLUSH duration is exactly FLUSH_CYCLES cycles.
  - exc_req, eret and HDU inputs are ignored.
- REDIRECT (1 cycle):
  - pc_load = 1; pc_target = cause[0] ? VEC_OPC : VEC_OVF; pc_enable = 1; flush_if_id = 1; other flushes = 0.
  - -> HANDLER.
- HANDLER:
  - Outputs as IDLE pass-through.
  - exc_req = 1 -> double fault: cause[1] <= 1, epc unchanged, all flushes = 1 and pc_enable = 0 that cycle, -> HALT.
  - Otherwise eret = 1 -> RESTORE.
  - exc_req and eret together: exc_req wins (HALT).
- RESTORE (1 cycle):
  - pc_load = 1; pc_target = epc; pc_enable = 1; flush_if_id = 1.
  - -> IDLE.
- HALT:
  - pc_enable = 0, if_id_write = 0, all flushes = 1, halted = 1.
  - Left only by rst_n.
- pc_target = 0 whenever pc_load = 0.
- eret in IDLE, FLUSH, REDIRECT or HALT is ignored.
- Reset asserted mid-sequence returns to IDLE immediately (asynchronous); no partial pc_load is issued after reset release.
- Exception latency: exc_req accepted at cycle N -> pc_load asserted at cycle N+FLUSH_CYCLES+1.

Decomposition:
- Shared package (e.g. datapath_pkg):
  - state enum (IDLE..HALT).
  - cause encodings (CAUSE_OVF = 0, CAUSE_OPC = 1).
  - which_flush encodings.
  - default vector constants.
- One natural sub-module: flush_counter (loadable 4-bit down-counter with zero flag).
- FSM and output decode stay in exception_sequencer.

Test Plan:
1. Reset, then hdu_stall = 1, hdu_which_flush = 2'b11 in IDLE -> pc_enable = 0, if_id_write = 0, flush_if_id = 1, flush_id_ex = 1, flush_ex_mem = 0, busy = 0.
2. exc_req = 1, exc_cause = 0, fault_pc = 16'h0010 at cycle N (FLUSH_CYCLES = 2):
   - Cycles N..N+2: all flushes = 1.
   - Cycle N+3: pc_load = 1, pc_target = 16'h0060.
   - Afterwards: epc = 16'h0010, cause = 2'b00, exc_count = 1.
3. Same as 2 with exc_cause = 1, fault_pc = 16'h8010 -> pc_target = 16'h0080 at N+3, cause = 2'b01. Then eret in HANDLER -> next cycle pc_load = 1, pc_target = 16'h8010, following cycle busy = 0.
4. In HANDLER, drive exc_req = 1 and eret = 1 together -> HALT: halted = 1, cause[1] = 1, epc unchanged, pc_enable stays 0 for 10+ cycles. Then rst_n pulse -> IDLE, all registers 0.
5. exc_req and eret pulsed during FLUSH and REDIRECT -> ignored: epc and exc_count unchanged, redirect timing identical to scenario 2.
6. Assert rst_n = 0 asynchronously mid-FLUSH (between clock edges) -> outputs return to IDLE values immediately, no pc_load after release. Finally, 256 exceptions -> exc_count saturates at 8'hFF.
